// File: rtl/regfile_sb.sv
// Register file with one hardwired-zero register and a per-register pending scoreboard.
// Reads are combinational, with optional same-cycle forwarding of the write port.
module regfile_sb #(
   parameter int WIDTH     = 64,
   parameter int ADDR_BITS = 5,
   parameter int ZERO_REG  = 31,
   parameter bit BYPASS    = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [ADDR_BITS-1:0] ReadRegister1,
   input  logic [ADDR_BITS-1:0] ReadRegister2,
   output logic [WIDTH-1:0]     ReadData1,
   output logic [WIDTH-1:0]     ReadData2,
   input  logic [ADDR_BITS-1:0] WriteRegister,
   input  logic [WIDTH-1:0]     WriteData,
   input  logic                 RegWrite,
   input  logic                 IssueValid,
   input  logic [ADDR_BITS-1:0] IssueRegister,
   output logic                 Busy1,
   output logic                 Busy2,
   output logic [ADDR_BITS:0]   PendingCount
);

   localparam int                   DEPTH    = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(ZERO_REG);

   logic [WIDTH-1:0] w_reg_q [DEPTH];
   logic [DEPTH-1:0] w_pend_q;
   logic [DEPTH-1:0] w_pend_nxt;
   logic             w_wr_en;
   logic             w_iss_en;
   logic             w_fwd1;
   logic             w_fwd2;
   logic [ADDR_BITS:0] w_count_nxt;
   logic [ADDR_BITS:0] r_count;

   assign w_wr_en  = RegWrite && (WriteRegister != ZERO_IDX);
   assign w_iss_en = IssueValid && (IssueRegister != ZERO_IDX);

   // The zero register gets neither a data flop nor a pending flop.
   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      localparam logic [ADDR_BITS-1:0] IDX = ADDR_BITS'(g);
      if (g == ZERO_REG) begin : g_zero
         assign w_reg_q[g]    = '0;
         assign w_pend_q[g]   = 1'b0;
         assign w_pend_nxt[g] = 1'b0;
      end else begin : g_live
         logic [WIDTH-1:0] r_data;
         logic             r_pend;
         logic             w_set;
         logic             w_clr;

         assign w_set = w_iss_en && (IssueRegister == IDX);
         assign w_clr = RegWrite && (WriteRegister == IDX);
         // A new producer issued on the same edge as the old one retires keeps the mark.
         assign w_pend_nxt[g] = w_set || (r_pend && !w_clr);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_data <= '0;
               r_pend <= 1'b0;
            end else begin
               if (w_wr_en && (WriteRegister == IDX)) begin
                  r_data <= WriteData;
               end
               r_pend <= w_pend_nxt[g];
            end
         end

         assign w_reg_q[g]  = r_data;
         assign w_pend_q[g] = r_pend;
      end
   end

   always_comb begin
      w_count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_count_nxt = w_count_nxt + (ADDR_BITS + 1)'(w_pend_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign PendingCount = r_count;

   assign w_fwd1 = BYPASS && RegWrite && (WriteRegister == ReadRegister1);
   assign w_fwd2 = BYPASS && RegWrite && (WriteRegister == ReadRegister2);

   // Forwarding is gated by reset so the outputs read 0 while reset is held.
   always_comb begin
      ReadData1 = '0;
      Busy1     = 1'b0;
      if (reset_n && (ReadRegister1 != ZERO_IDX)) begin
         ReadData1 = w_fwd1 ? WriteData : w_reg_q[ReadRegister1];
         Busy1     = w_pend_q[ReadRegister1] && !w_fwd1;
      end
   end

   always_comb begin
      ReadData2 = '0;
      Busy2     = 1'b0;
      if (reset_n && (ReadRegister2 != ZERO_IDX)) begin
         ReadData2 = w_fwd2 ? WriteData : w_reg_q[ReadRegister2];
         Busy2     = w_pend_q[ReadRegister2] && !w_fwd2;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share one stimulus
// stream; a reference model predicts both, and a monitor checks every cycle.
module tb_regfile_sb;

   localparam int W     = 64;
   localparam int AB    = 5;
   localparam int DEPTH = 32;
   localparam int ZR    = 31;
   localparam int CW    = AB + 1;
   localparam int EW    = 4 * W + 4 + CW;
   localparam logic [AB-1:0] ZA = AB'(ZR);
   localparam logic [W-1:0]  K  = 64'h0000010204080001;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [AB-1:0] ReadRegister1 = '0, ReadRegister2 = '0;
   logic [AB-1:0] WriteRegister = '0, IssueRegister = '0;
   logic [W-1:0]  WriteData = '0;
   logic          RegWrite = 1'b0, IssueValid = 1'b0;

   logic [W-1:0]  rd1_bp, rd2_bp, rd1_nb, rd2_nb;
   logic          b1_bp, b2_bp, b1_nb, b2_nb;
   logic [CW-1:0] cnt_bp, cnt_nb;

   regfile_sb #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(ZR), .BYPASS(1'b1)) u_dut_bp (
      .clk(clk), .reset_n(reset_n),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(rd1_bp), .ReadData2(rd2_bp),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
      .IssueValid(IssueValid), .IssueRegister(IssueRegister),
      .Busy1(b1_bp), .Busy2(b2_bp), .PendingCount(cnt_bp)
   );

   regfile_sb #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(ZR), .BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .reset_n(reset_n),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(rd1_nb), .ReadData2(rd2_nb),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
      .IssueValid(IssueValid), .IssueRegister(IssueRegister),
      .Busy1(b1_nb), .Busy2(b2_nb), .PendingCount(cnt_nb)
   );

   // reference model: architectural register contents and the set of pending registers
   logic [W-1:0] m_regs [DEPTH];
   bit           m_pend [DEPTH];
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [W-1:0] model_read(input logic [AB-1:0] a, input bit bp);
      if (!reset_n || a == ZA) return '0;
      if (bp && RegWrite && WriteRegister == a) return WriteData;
      return m_regs[a];
   endfunction

   function automatic bit model_busy(input logic [AB-1:0] a, input bit bp);
      if (!reset_n || a == ZA) return 1'b0;
      if (bp && RegWrite && WriteRegister == a) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // driver: drive one cycle of inputs, predict outputs, then advance the model across the edge
   task automatic cycle(input bit rst, input bit we, input logic [AB-1:0] wa,
                        input logic [W-1:0] wd, input bit iv, input logic [AB-1:0] ia,
                        input logic [AB-1:0] r1, input logic [AB-1:0] r2);
      @(posedge clk);
      #1;
      reset_n = rst;
      RegWrite = we; WriteRegister = wa; WriteData = wd;
      IssueValid = iv; IssueRegister = ia;
      ReadRegister1 = r1; ReadRegister2 = r2;
      if (!rst) model_clear();
      exp_q.push_back({model_read(r1, 1'b1), model_read(r2, 1'b1),
                       model_busy(r1, 1'b1), model_busy(r2, 1'b1),
                       model_read(r1, 1'b0), model_read(r2, 1'b0),
                       model_busy(r1, 1'b0), model_busy(r2, 1'b0),
                       CW'(model_count())});
      if (rst) begin
         if (we && wa != ZA) m_regs[wa] = wd;
         if (we) m_pend[wa] = 1'b0;
         if (iv && ia != ZA) m_pend[ia] = 1'b1;
      end
   endtask

   task automatic idle_read(input logic [AB-1:0] r1, input logic [AB-1:0] r2);
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, r1, r2);
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         check("rd1_bp", rd1_bp, e[265:202]);
         check("rd2_bp", rd2_bp, e[201:138]);
         check("busy1_bp", W'(b1_bp), W'(e[137]));
         check("busy2_bp", W'(b2_bp), W'(e[136]));
         check("rd1_nb", rd1_nb, e[135:72]);
         check("rd2_nb", rd2_nb, e[71:8]);
         check("busy1_nb", W'(b1_nb), W'(e[7]));
         check("busy2_nb", W'(b2_nb), W'(e[6]));
         check("count_bp", W'(cnt_bp), W'(e[5:0]));
         check("count_nb", W'(cnt_nb), W'(e[5:0]));
      end
   end

   function automatic logic [AB-1:0] pick();
      if ($urandom_range(0, 1) == 1) return AB'($urandom_range(0, 7));
      return AB'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      logic [AB-1:0] wa, ia, r1, r2;
      model_clear();

      // writes and issues held off during reset
      cycle(1'b0, 1'b1, 5'd3, 64'hDEAD, 1'b1, 5'd4, 5'd3, 5'd4);
      cycle(1'b0, 1'b1, 5'd3, 64'hBEEF, 1'b1, 5'd4, 5'd3, 5'd4);
      idle_read(5'd3, 5'd4);

      // zero register discards writes
      cycle(1'b1, 1'b1, ZA, 64'hA0, 1'b0, '0, ZA, ZA);
      idle_read(ZA, ZA);

      // write/read-back walk across every register
      for (int i = 0; i < ZR; i++) cycle(1'b1, 1'b1, AB'(i), W'(i) * K, 1'b0, '0, AB'(i), ZA);
      for (int i = 0; i < DEPTH; i++) idle_read(AB'(i), AB'(DEPTH - 1 - i));

      // same-cycle forwarding versus old value
      cycle(1'b1, 1'b1, 5'd5, 64'h1234, 1'b0, '0, 5'd5, 5'd5);
      idle_read(5'd5, 5'd5);

      // issue then retire
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
      idle_read(5'd7, 5'd7);
      cycle(1'b1, 1'b1, 5'd7, 64'h77, 1'b0, '0, 5'd7, 5'd7);
      idle_read(5'd7, 5'd7);

      // set/clear collision on one register, independent updates on two
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
      cycle(1'b1, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9, 5'd9);
      idle_read(5'd9, 5'd9);
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd4);
      cycle(1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 5'd3, 5'd3, 5'd4);
      idle_read(5'd3, 5'd4);
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd3);
      idle_read(5'd3, 5'd3);

      // reset dropped between edges with several marks outstanding
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd1, 5'd1, 5'd2);
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd2, 5'd1, 5'd2);
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 5'd1, 5'd2);
      idle_read(5'd1, 5'd3);
      cycle(1'b0, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 5'd1, 5'd5);
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd1, 5'd1, 5'd5);
      idle_read(5'd1, 5'd2);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         wa = pick();
         ia = ($urandom_range(0, 3) == 0) ? wa : pick();
         r1 = ($urandom_range(0, 3) == 0) ? wa : pick();
         r2 = ($urandom_range(0, 3) == 0) ? ia : pick();
         cycle(($urandom_range(0, 79) != 0), ($urandom_range(0, 1) == 1), wa,
               {$urandom, $urandom}, ($urandom_range(0, 2) != 0), ia, r1, r2);
      end

      // drain scoreboard with a bounded wait
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain act=%0d exp=0 entries left", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
